// File: rtl/core_wbq_if.sv
// ---------------------------------------------------------------------------
// core_wbq_if
// Bus bundle for the writeback queue. One interface carries three channels:
//   result channel : in_valid, in_ready, in_addr[3:0], in_data[15:0]
//   ARF write port : w_en, w_addr[3:0], w_data[15:0]
//   forwarding     : fwd_addr[3:0], fwd_hit, fwd_data[15:0]
// Modports:
//   master : the execution side that offers results and looks up operands.
//   slave  : the queue itself.
// ---------------------------------------------------------------------------
interface core_wbq_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_addr;
  logic [15:0] in_data;

  logic        w_en;
  logic [3:0]  w_addr;
  logic [15:0] w_data;

  logic [3:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;

  modport master (
    output in_valid, in_addr, in_data, fwd_addr,
    input  in_ready, w_en, w_addr, w_data, fwd_hit, fwd_data
  );

  modport slave (
    input  in_valid, in_addr, in_data, fwd_addr,
    output in_ready, w_en, w_addr, w_data, fwd_hit, fwd_data
  );
endinterface

// File: rtl/core_wbq.sv
// ---------------------------------------------------------------------------
// core_wbq
// Writeback queue between the execution units and the architectural register
// file (ARF). Results are buffered in a circular FIFO and drained one per
// cycle into the ARF write port, strictly in arrival order. Queued results
// can be forwarded to operand reads, and a per-register pending mask tells
// the issue logic which registers still have a write in flight.
//
// Ports:
//   clk_i    : clock, rising edge
//   arst_ni  : asynchronous active-low reset
//   bus      : core_wbq_if.slave (result channel, ARF write port, forwarding)
//   stall_i  : hold the drain; enqueue still allowed
//   flush_i  : discard every queued result at the next edge
//   pending  : bit k set when a queued entry targets register k
//   count    : number of occupied entries
//
// Parameter:
//   DEPTH    : number of entries, power of two in 2..16
// ---------------------------------------------------------------------------
module core_wbq #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  core_wbq_if.slave                bus,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic [15:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Payload storage carries no reset: an entry is only ever observed while
  // it is occupied, and occupancy is tracked by the reset pointers/count.
  logic [3:0]  addr_q [DEPTH];
  logic [15:0] data_q [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic do_enq;
  logic do_deq;
  logic [PTR_W-1:0] idx;

  // Acceptance never depends on the drain in the same cycle, so a full
  // queue refuses even while it is writing an entry out.
  assign bus.in_ready = ~flush_i & (count_q < DEPTH_C);

  // R0 is hardwired to zero: the handshake completes but nothing is stored.
  assign do_enq = bus.in_valid & bus.in_ready & (bus.in_addr != 4'd0);

  assign bus.w_en   = (count_q != '0) & ~stall_i & ~flush_i;
  assign bus.w_addr = bus.w_en ? addr_q[head_q] : 4'd0;
  assign bus.w_data = bus.w_en ? data_q[head_q] : 16'd0;
  assign do_deq     = bus.w_en;

  assign count = count_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_enq) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (do_deq) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_enq) begin
      addr_q[tail_q] <= bus.in_addr;
      data_q[tail_q] <= bus.in_data;
    end
  end

  // Walk the occupied entries from oldest (head) to youngest; later matches
  // overwrite earlier ones so the youngest write to a register wins. The
  // entry being enqueued this cycle is not yet occupied and is not seen.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = 16'd0;
    pending      = 16'd0;
    idx          = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (CNT_W'(k) < count_q) begin
        pending[addr_q[idx]] = 1'b1;
        if ((bus.fwd_addr != 4'd0) && (addr_q[idx] == bus.fwd_addr)) begin
          bus.fwd_hit  = 1'b1;
          bus.fwd_data = data_q[idx];
        end
      end
    end
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_core_wbq.sv
// ---------------------------------------------------------------------------
// tb_core_wbq
// Directed self-checking bench for core_wbq with DEPTH = 4. Inputs are
// changed just after a rising edge and outputs are sampled a little later in
// the same cycle, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_core_wbq;

  logic        clk_i;
  logic        arst_ni;
  logic        stall_i;
  logic        flush_i;
  logic [15:0] pending;
  logic [2:0]  count;

  int checks;
  int passed;

  core_wbq_if bus ();

  core_wbq #(.DEPTH(4)) dut (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .bus     (bus.slave),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .pending (pending),
    .count   (count)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic valid, input logic [3:0] addr,
                               input logic [15:0] data, input logic stall,
                               input logic flush, input logic [3:0] faddr);
    bus.in_valid = valid;
    bus.in_addr  = addr;
    bus.in_data  = data;
    stall_i      = stall;
    flush_i      = flush;
    bus.fwd_addr = faddr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    arst_ni = 1'b0;
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0);

    // Reset state
    #2;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_w_en",     32'(bus.w_en),     32'd0);
    checkOutput("rst_w_addr",   32'(bus.w_addr),   32'd0);
    checkOutput("rst_w_data",   32'(bus.w_data),   32'd0);
    checkOutput("rst_fwd_hit",  32'(bus.fwd_hit),  32'd0);
    checkOutput("rst_fwd_data", 32'(bus.fwd_data), 32'd0);
    checkOutput("rst_pending",  32'(pending),      32'd0);
    checkOutput("rst_count",    32'(count),        32'd0);
    tick();
    arst_ni = 1'b1;
    tick();

    // Single result: minimum latency of one cycle
    $display("[TB] single result");
    applyStimulus(1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 4'd0);
    checkOutput("single_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("single_w_en0", 32'(bus.w_en),     32'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0);
    checkOutput("single_w_en1", 32'(bus.w_en),   32'd1);
    checkOutput("single_w_addr", 32'(bus.w_addr), 32'd3);
    checkOutput("single_w_data", 32'(bus.w_data), 32'h1234);
    checkOutput("single_count1", 32'(count),      32'd1);
    checkOutput("single_pending", 32'(pending),   32'h0008);
    tick();
    checkOutput("single_w_en2",  32'(bus.w_en), 32'd0);
    checkOutput("single_count2", 32'(count),    32'd0);

    // R0 results are accepted but dropped
    $display("[TB] R0 discard");
    applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 4'd0);
    checkOutput("r0_ready", 32'(bus.in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0);
    checkOutput("r0_count",   32'(count),     32'd0);
    checkOutput("r0_w_en",    32'(bus.w_en),  32'd0);
    checkOutput("r0_pending", 32'(pending),   32'd0);

    // Forwarding: youngest wins, same-cycle enqueue is invisible
    $display("[TB] forwarding");
    applyStimulus(1'b1, 4'd5, 16'h00AA, 1'b1, 1'b0, 4'd5);
    checkOutput("fwd_same_cycle_hit", 32'(bus.fwd_hit), 32'd0);
    tick();
    applyStimulus(1'b1, 4'd5, 16'h00BB, 1'b1, 1'b0, 4'd5);
    checkOutput("fwd_older_hit",  32'(bus.fwd_hit),  32'd1);
    checkOutput("fwd_older_data", 32'(bus.fwd_data), 32'h00AA);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd5);
    checkOutput("fwd_young_hit",  32'(bus.fwd_hit),  32'd1);
    checkOutput("fwd_young_data", 32'(bus.fwd_data), 32'h00BB);
    checkOutput("fwd_count",      32'(count),        32'd2);
    checkOutput("fwd_stall_w_en", 32'(bus.w_en),     32'd0);
    checkOutput("fwd_pending",    32'(pending),      32'h0020);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd6);
    checkOutput("fwd_miss_hit",  32'(bus.fwd_hit),  32'd0);
    checkOutput("fwd_miss_data", 32'(bus.fwd_data), 32'd0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd0);
    checkOutput("fwd_r0_hit", 32'(bus.fwd_hit), 32'd0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0);
    checkOutput("fwd_drain0_w_en", 32'(bus.w_en),   32'd1);
    checkOutput("fwd_drain0_data", 32'(bus.w_data), 32'h00AA);
    tick();
    checkOutput("fwd_drain1_addr", 32'(bus.w_addr), 32'd5);
    checkOutput("fwd_drain1_data", 32'(bus.w_data), 32'h00BB);
    tick();
    checkOutput("fwd_drain_done", 32'(bus.w_en), 32'd0);

    // Fill under stall, back-pressure, then in-order drain
    $display("[TB] fill and back-pressure");
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 4'(k), 16'h1000 + 16'(k), 1'b1, 1'b0, 4'd0);
      checkOutput("fill_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    applyStimulus(1'b1, 4'd5, 16'h1005, 1'b1, 1'b0, 4'd0);
    checkOutput("full_ready",   32'(bus.in_ready), 32'd0);
    checkOutput("full_count",   32'(count),        32'd4);
    checkOutput("full_pending", 32'(pending),      32'h001E);
    checkOutput("full_w_en",    32'(bus.w_en),     32'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0);
    checkOutput("full_no_passthru", 32'(bus.in_ready), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("drain_w_en",   32'(bus.w_en),   32'd1);
      checkOutput("drain_w_addr", 32'(bus.w_addr), 32'(k));
      checkOutput("drain_w_data", 32'(bus.w_data), 32'h1000 + 32'(k));
      tick();
    end
    checkOutput("drain_empty_w_en",  32'(bus.w_en), 32'd0);
    checkOutput("drain_empty_count", 32'(count),    32'd0);
    applyStimulus(1'b1, 4'd5, 16'h1005, 1'b0, 1'b0, 4'd0);
    checkOutput("r5_ready", 32'(bus.in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0);
    checkOutput("r5_w_addr", 32'(bus.w_addr), 32'd5);
    checkOutput("r5_w_data", 32'(bus.w_data), 32'h1005);
    tick();
    checkOutput("r5_count", 32'(count), 32'd0);

    // Flush takes priority, then enqueue/dequeue pairs across the wrap
    $display("[TB] flush and wrap");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 4'd7 + 4'(k), 16'h2000 + 16'(k), 1'b1, 1'b0, 4'd0);
      tick();
    end
    applyStimulus(1'b1, 4'd10, 16'h200A, 1'b0, 1'b1, 4'd7);
    checkOutput("flush_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("flush_w_en",  32'(bus.w_en),     32'd0);
    checkOutput("flush_count_before", 32'(count), 32'd3);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd7);
    checkOutput("flush_count",   32'(count),       32'd0);
    checkOutput("flush_w_en2",   32'(bus.w_en),    32'd0);
    checkOutput("flush_pending", 32'(pending),     32'd0);
    checkOutput("flush_fwd_hit", 32'(bus.fwd_hit), 32'd0);
    applyStimulus(1'b1, 4'd1, 16'h3001, 1'b0, 1'b0, 4'd0);
    tick();
    for (int k = 2; k <= 6; k++) begin
      applyStimulus(1'b1, 4'(k), 16'h3000 + 16'(k), 1'b0, 1'b0, 4'd0);
      checkOutput("wrap_w_en",   32'(bus.w_en),   32'd1);
      checkOutput("wrap_w_addr", 32'(bus.w_addr), 32'(k - 1));
      checkOutput("wrap_w_data", 32'(bus.w_data), 32'h3000 + 32'(k - 1));
      checkOutput("wrap_count",  32'(count),      32'd1);
      tick();
    end
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0);
    checkOutput("wrap_last_addr", 32'(bus.w_addr), 32'd6);
    checkOutput("wrap_last_data", 32'(bus.w_data), 32'h3006);
    tick();
    checkOutput("wrap_empty", 32'(count), 32'd0);

    // Asynchronous reset mid-drain
    $display("[TB] async reset");
    applyStimulus(1'b1, 4'd2, 16'h4002, 1'b1, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b1, 4'd4, 16'h4004, 1'b1, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd4);
    checkOutput("arst_pre_w_en",  32'(bus.w_en), 32'd1);
    checkOutput("arst_pre_count", 32'(count),    32'd2);
    #2;
    arst_ni = 1'b0;
    #1;
    checkOutput("arst_w_en",     32'(bus.w_en),     32'd0);
    checkOutput("arst_w_addr",   32'(bus.w_addr),   32'd0);
    checkOutput("arst_count",    32'(count),        32'd0);
    checkOutput("arst_pending",  32'(pending),      32'd0);
    checkOutput("arst_fwd_hit",  32'(bus.fwd_hit),  32'd0);
    checkOutput("arst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    arst_ni = 1'b1;
    #1;
    checkOutput("arst_after_w_en",  32'(bus.w_en), 32'd0);
    checkOutput("arst_after_count", 32'(count),    32'd0);
    tick();
    checkOutput("arst_after_w_en2", 32'(bus.w_en), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
